alu_arbiter: RTL and testbench

- Shares one 4-bit ALU datapath (calculator core: A, B, sel in; result and Z/C/N/V flags out) between two independent requesters.
- Round-robin arbitration with a req/gnt/done handshake.
- Holds the ALU operands stable for a programmable settle latency, captures the result and flags, and returns them to the winning requester.
- Sits between the user-facing control logic (switch/FSM requesters) and the ALU instance.

---
 rtl/alu_arb_pkg.sv | 37 +++
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, {Z,C,N,V} flag struct, calculator opcodes,
// one-hot helper used for the grant/done vectors.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    // Opcodes understood by the shared calculator core
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;

    // Width of the optional per-requester grant counters
    localparam int STAT_W = 8;

    // Requester index -> one-hot 2-bit vector
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundles the requester-side handshake and the ALU-side operand/result bus.
// Latency: none (wiring only).
// Backpressure: req is a level held by the requester until it sees gnt.
//
// slave  : arbiter view (takes requests and ALU results, drives grants/ALU operands)
// master : environment view (requesters + ALU instance)
// Optional macro ALU_ARB_STATS_EN adds the gcnt0/gcnt1 grant counters.
interface alu_arbiter_if #(
    parameter int W     = 4,
    parameter int SEL_W = 4
);
    // requester side
    logic [1:0]       req;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic [SEL_W-1:0] sel0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic [SEL_W-1:0] sel1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [W-1:0]     res;
    logic [3:0]       flags;
    logic             busy;
    // ALU side
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [W-1:0]     alu_res;
    logic [3:0]       alu_flags;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]       gcnt0;
    logic [7:0]       gcnt1;

    modport slave (
        input  req, a0, b0, sel0, a1, b1, sel1, alu_res, alu_flags,
        output gnt, done, res, flags, busy, alu_a, alu_b, alu_sel, gcnt0, gcnt1
    );
    modport master (
        output req, a0, b0, sel0, a1, b1, sel1, alu_res, alu_flags,
        input  gnt, done, res, flags, busy, alu_a, alu_b, alu_sel, gcnt0, gcnt1
    );
`else
    modport slave (
        input  req, a0, b0, sel0, a1, b1, sel1, alu_res, alu_flags,
        output gnt, done, res, flags, busy, alu_a, alu_b, alu_sel
    );
    modport master (
        output req, a0, b0, sel0, a1, b1, sel1, alu_res, alu_flags,
        input  gnt, done, res, flags, busy, alu_a, alu_b, alu_sel
    );
`endif

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin pick between requesters 0 and 1.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports: i_req[1:0] request levels, i_last = previous winner,
//        o_winner = chosen index, o_valid = any request present.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_valid
);

    // On a tie the requester that did not win last time goes first;
    // a lone request wins outright regardless of history.
    assign o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];
    assign o_valid  = |i_req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
// Latency: req sampled at t -> gnt at t+1 -> done at t+LAT+1; one op per LAT+2 cycles.
// Backpressure: requesters hold req (level) until granted; no new grant while busy.
//
// Ports: clk, rst (async active-low), bus (alu_arbiter_if.slave: req/operands in,
//        gnt/done/res/flags/busy out, alu_a/alu_b/alu_sel out, alu_res/alu_flags in).
// LAT = ALU settle cycles, legal 1..15.
// Optional macro ALU_ARB_STATS_EN adds saturating per-requester grant counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int W     = 4,
    parameter int SEL_W = 4,
    parameter int LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    // WAIT counts down from LAT-2 so that, with the ISSUE cycle, the ALU
    // has exactly LAT cycles of stable operands before capture.
    localparam logic [3:0] CNT_LOAD = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_issue;
    logic             w_capture;
    logic             w_winner;
    logic             w_valid;

    logic             r_last;
    logic             r_owner;
    logic [3:0]       r_cnt;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             r_busy;
    logic [W-1:0]     r_res;
    flags_t           r_flags;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [SEL_W-1:0] r_alu_sel;

    rr_arb2 u_rr_arb2 (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ISSUE;
                    w_issue     = 1'b1;
                end
            end
            ISSUE: begin
                if (LAT == 1) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: ownership, operand latch, settle counter, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last    <= 1'b1;  // requester 0 takes the first tie
            r_owner   <= 1'b0;
            r_cnt     <= 4'd0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_busy    <= 1'b0;
            r_res     <= '0;
            r_flags   <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else begin
            r_gnt  <= w_issue ? onehot2(w_winner) : 2'b00;
            // r_owner is already stable by the time capture can happen
            r_done <= w_capture ? onehot2(r_owner) : 2'b00;
            r_busy <= (w_state_nxt != IDLE);

            // Operands are latched once at grant; later requester changes
            // cannot disturb the ALU mid-operation.
            if (w_issue) begin
                r_owner   <= w_winner;
                r_last    <= w_winner;
                r_alu_a   <= w_winner ? bus.a1   : bus.a0;
                r_alu_b   <= w_winner ? bus.b1   : bus.b0;
                r_alu_sel <= w_winner ? bus.sel1 : bus.sel0;
            end

            if (r_state == ISSUE) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                r_res   <= bus.alu_res;
                r_flags <= flags_t'(bus.alu_flags);
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.res     = r_res;
    assign bus.flags   = r_flags;
    assign bus.alu_a   = r_alu_a;
    assign bus.alu_b   = r_alu_b;
    assign bus.alu_sel = r_alu_sel;

`ifdef ALU_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating grant counters, one per requester
    // ------------------------------------------------------------------
    logic [STAT_W-1:0] r_gcnt0;
    logic [STAT_W-1:0] r_gcnt1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
        end else begin
            if (w_issue && !w_winner && (r_gcnt0 != '1)) begin
                r_gcnt0 <= r_gcnt0 + 1'b1;
            end
            if (w_issue && w_winner && (r_gcnt1 != '1)) begin
                r_gcnt1 <= r_gcnt1 + 1'b1;
            end
        end
    end

    assign bus.gcnt0 = r_gcnt0;
    assign bus.gcnt1 = r_gcnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: two arbiters (LAT=2 and LAT=1) share one stimulus stream.
// Each has its own bench ALU and a timestamp-based reference model; every cycle
// all outputs are compared, plus hand-computed expectations at key points.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // shared requester stimulus
    logic [1:0] s_req  = 2'b00;
    logic [3:0] s_a0   = 4'h0;
    logic [3:0] s_b0   = 4'h0;
    logic [3:0] s_sel0 = 4'h0;
    logic [3:0] s_a1   = 4'h0;
    logic [3:0] s_b1   = 4'h0;
    logic [3:0] s_sel1 = 4'h0;

    alu_arbiter_if #(.W(4), .SEL_W(4)) bus2 ();
    alu_arbiter_if #(.W(4), .SEL_W(4)) bus1 ();

    // Reference calculator: returns {Z,C,N,V,res}; C is carry on add, borrow on sub
    function automatic logic [7:0] alu4(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s);
        logic [4:0] t;
        logic       c;
        logic       v;
        t = 5'd0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                c = t[4];
                v = (a[3] == b[3]) && (t[3] != a[3]);
            end
            OP_SUB: begin
                t = {1'b0, a} - {1'b0, b};
                c = t[4];
                v = (a[3] != b[3]) && (t[3] != a[3]);
            end
            OP_AND: t = {1'b0, a & b};
            OP_OR:  t = {1'b0, a | b};
            default: t = 5'd0;
        endcase
        return {(t[3:0] == 4'd0), c, t[3], v, t[3:0]};
    endfunction

    assign bus2.req = s_req;  assign bus1.req = s_req;
    assign bus2.a0 = s_a0;    assign bus1.a0 = s_a0;
    assign bus2.b0 = s_b0;    assign bus1.b0 = s_b0;
    assign bus2.sel0 = s_sel0; assign bus1.sel0 = s_sel0;
    assign bus2.a1 = s_a1;    assign bus1.a1 = s_a1;
    assign bus2.b1 = s_b1;    assign bus1.b1 = s_b1;
    assign bus2.sel1 = s_sel1; assign bus1.sel1 = s_sel1;
    assign {bus2.alu_flags, bus2.alu_res} = alu4(bus2.alu_a, bus2.alu_b, bus2.alu_sel);
    assign {bus1.alu_flags, bus1.alu_res} = alu4(bus1.alu_a, bus1.alu_b, bus1.alu_sel);

    alu_arbiter #(.W(4), .SEL_W(4), .LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    alu_arbiter #(.W(4), .SEL_W(4), .LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // ------------------------------------------------------------------
    // Reference model. Index 0 = LAT 2 instance, 1 = LAT 1 instance.
    // An operation is tracked by the number of edges since its grant:
    // done is shown after edge L, the arbiter is free again after edge L+1.
    // ------------------------------------------------------------------
    int         m_lat  [2] = '{2, 1};
    bit         m_act  [2] = '{0, 0};
    int         m_d    [2] = '{0, 0};
    bit         m_last [2] = '{1, 1};
    bit         m_own  [2] = '{0, 0};
    logic [1:0] e_gnt  [2] = '{2'b00, 2'b00};
    logic [1:0] e_done [2] = '{2'b00, 2'b00};
    bit         e_busy [2] = '{0, 0};
    logic [3:0] e_a    [2] = '{4'h0, 4'h0};
    logic [3:0] e_b    [2] = '{4'h0, 4'h0};
    logic [3:0] e_sel  [2] = '{4'h0, 4'h0};
    logic [3:0] e_res  [2] = '{4'h0, 4'h0};
    logic [3:0] e_flg  [2] = '{4'h0, 4'h0};
    int         e_g0   [2] = '{0, 0};
    int         e_g1   [2] = '{0, 0};

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_act[k] = 0;  m_d[k] = 0;  m_last[k] = 1;  m_own[k] = 0;
                e_gnt[k] = 2'b00;  e_done[k] = 2'b00;  e_busy[k] = 0;
                e_a[k] = 4'h0;  e_b[k] = 4'h0;  e_sel[k] = 4'h0;
                e_res[k] = 4'h0;  e_flg[k] = 4'h0;  e_g0[k] = 0;  e_g1[k] = 0;
            end else begin
                e_gnt[k]  = 2'b00;
                e_done[k] = 2'b00;
                if (m_act[k]) begin
                    m_d[k] = m_d[k] + 1;
                    if (m_d[k] == m_lat[k]) begin
                        e_done[k] = m_own[k] ? 2'b10 : 2'b01;
                        {e_flg[k], e_res[k]} = alu4(e_a[k], e_b[k], e_sel[k]);
                    end else if (m_d[k] == m_lat[k] + 1) begin
                        m_act[k]  = 0;
                        e_busy[k] = 0;
                    end
                end else if (s_req != 2'b00) begin
                    m_own[k]  = (s_req == 2'b11) ? !m_last[k] : s_req[1];
                    m_last[k] = m_own[k];
                    m_act[k]  = 1;
                    m_d[k]    = 0;
                    e_busy[k] = 1;
                    e_gnt[k]  = m_own[k] ? 2'b10 : 2'b01;
                    e_a[k]    = m_own[k] ? s_a1 : s_a0;
                    e_b[k]    = m_own[k] ? s_b1 : s_b0;
                    e_sel[k]  = m_own[k] ? s_sel1 : s_sel0;
                    if (m_own[k]) e_g1[k] = (e_g1[k] < 255) ? e_g1[k] + 1 : 255;
                    else          e_g0[k] = (e_g0[k] < 255) ? e_g0[k] + 1 : 255;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic [1:0] g, input logic [1:0] d,
                       input logic b, input logic [3:0] aa, input logic [3:0] ab,
                       input logic [3:0] as, input logic [3:0] r, input logic [3:0] f);
        chk($sformatf("i%0d gnt", k),   32'(g),  32'(e_gnt[k]));
        chk($sformatf("i%0d done", k),  32'(d),  32'(e_done[k]));
        chk($sformatf("i%0d busy", k),  32'(b),  32'(e_busy[k]));
        chk($sformatf("i%0d alu_a", k), 32'(aa), 32'(e_a[k]));
        chk($sformatf("i%0d alu_b", k), 32'(ab), 32'(e_b[k]));
        chk($sformatf("i%0d alu_sel", k), 32'(as), 32'(e_sel[k]));
        chk($sformatf("i%0d res", k),   32'(r),  32'(e_res[k]));
        chk($sformatf("i%0d flags", k), 32'(f),  32'(e_flg[k]));
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp(0, bus2.gnt, bus2.done, bus2.busy, bus2.alu_a, bus2.alu_b, bus2.alu_sel,
            bus2.res, bus2.flags);
        cmp(1, bus1.gnt, bus1.done, bus1.busy, bus1.alu_a, bus1.alu_b, bus1.alu_sel,
            bus1.res, bus1.flags);
`ifdef ALU_ARB_STATS_EN
        chk("i0 gcnt0", 32'(bus2.gcnt0), 32'(e_g0[0]));
        chk("i0 gcnt1", 32'(bus2.gcnt1), 32'(e_g1[0]));
        chk("i1 gcnt0", 32'(bus1.gcnt0), 32'(e_g0[1]));
        chk("i1 gcnt1", 32'(bus1.gcnt1), 32'(e_g1[1]));
`endif
    end

    logic [1:0] g_seq [10];
    logic [1:0] d_seq [10];
    logic [1:0] seen2, seen1, seen_d;

    initial begin
        // ---- reset with random requests ----
        repeat (4) begin
            @(negedge clk);
            s_req = 2'($urandom_range(3));
            s_a0 = 4'($urandom_range(15));  s_b0 = 4'($urandom_range(15));
            s_a1 = 4'($urandom_range(15));  s_b1 = 4'($urandom_range(15));
        end
        @(negedge clk);
        chk("rst gnt", 32'(bus2.gnt), 32'h0);
        chk("rst busy", 32'(bus1.busy), 32'h0);
        chk("rst alu_a", 32'(bus2.alu_a), 32'h0);
        chk("rst res", 32'(bus1.res), 32'h0);
        s_req = 2'b00;
        #2 rst = 1'b1;

        // ---- single request, 3 + 13 ----
        @(negedge clk);
        s_a0 = 4'b0011;  s_b0 = 4'b1101;  s_sel0 = OP_ADD;  s_req = 2'b01;
        @(negedge clk);
        chk("t1 gnt", 32'(bus2.gnt), 32'h1);
        chk("t1 alu_a", 32'(bus2.alu_a), 32'h3);
        s_req = 2'b00;
        @(negedge clk);
        chk("t1 lat1 done", 32'(bus1.done), 32'h1);
        chk("t1 lat1 flags", 32'(bus1.flags), 32'hC);
        @(negedge clk);
        chk("t1 lat2 done", 32'(bus2.done), 32'h1);
        chk("t1 lat2 res", 32'(bus2.res), 32'h0);
        chk("t1 lat2 flags", 32'(bus2.flags), 32'hC);
        repeat (2) @(negedge clk);

        // ---- tie held: alternation on the LAT 1 instance ----
        s_a0 = 4'h1;  s_b0 = 4'h1;  s_sel0 = OP_ADD;
        s_a1 = 4'h5;  s_b1 = 4'h2;  s_sel1 = OP_SUB;
        s_req = 2'b11;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            g_seq[i] = bus1.gnt;
            d_seq[i] = bus1.done;
        end
        s_req = 2'b00;
        // requester 0 won last, so the first tie goes to requester 1
        chk("t2 gnt1", 32'(g_seq[1]), 32'h2);
        chk("t2 gap", 32'(g_seq[2] | g_seq[3]), 32'h0);
        chk("t2 gnt4", 32'(g_seq[4]), 32'h1);
        chk("t2 gnt7", 32'(g_seq[7]), 32'h2);
        chk("t2 done2", 32'(d_seq[2]), 32'h2);
        chk("t2 done5", 32'(d_seq[5]), 32'h1);
        chk("t2 done8", 32'(d_seq[8]), 32'h2);
        repeat (6) @(negedge clk);

        // ---- operand change after grant, 7 - 2 ----
        s_a1 = 4'b0111;  s_b1 = 4'b0010;  s_sel1 = OP_SUB;  s_req = 2'b10;
        @(negedge clk);
        chk("t3 gnt", 32'(bus2.gnt), 32'h2);
        s_req = 2'b00;
        @(negedge clk);
        s_a1 = 4'b1111;
        chk("t3 lat1 res", 32'(bus1.res), 32'h5);
        @(negedge clk);
        chk("t3 alu_a held", 32'(bus2.alu_a), 32'h7);
        chk("t3 done", 32'(bus2.done), 32'h2);
        chk("t3 res", 32'(bus2.res), 32'h5);
        chk("t3 flags", 32'(bus2.flags), 32'h0);
        repeat (3) @(negedge clk);

        // ---- withdraw: req0 pulsed while requester 1 is busy ----
        s_a1 = 4'h1;  s_b1 = 4'h1;  s_sel1 = OP_ADD;  s_req = 2'b10;
        @(negedge clk);
        s_req = 2'b11;
        @(negedge clk);
        s_req = 2'b00;
        seen2 = 2'b00;  seen1 = 2'b00;  seen_d = 2'b00;
        seen_d = seen_d | bus1.done;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen2  = seen2 | bus2.gnt;
            seen1  = seen1 | bus1.gnt;
            seen_d = seen_d | bus2.done;
        end
        chk("t4 no gnt i0", 32'(seen2), 32'h0);
        chk("t4 no gnt i1", 32'(seen1), 32'h0);
        chk("t4 done1", 32'(seen_d), 32'h2);

        // ---- reset during WAIT, then re-present ----
        s_a0 = 4'h2;  s_b0 = 4'h3;  s_sel0 = OP_ADD;  s_req = 2'b01;
        @(negedge clk);
        chk("t5 gnt", 32'(bus2.gnt), 32'h1);
        s_req = 2'b00;
        @(negedge clk);
        #2 rst = 1'b0;
        seen_d = 2'b00;
        repeat (3) begin
            @(negedge clk);
            seen_d = seen_d | bus2.done;
        end
        chk("t5 no done", 32'(seen_d), 32'h0);
        chk("t5 idle", 32'(bus2.busy), 32'h0);
        #2 rst = 1'b1;
        @(negedge clk);
        s_req = 2'b01;
        @(negedge clk);
        chk("t5 regnt", 32'(bus2.gnt), 32'h1);
        s_req = 2'b00;
        repeat (2) @(negedge clk);
        chk("t5 done", 32'(bus2.done), 32'h1);
        chk("t5 res", 32'(bus2.res), 32'h5);
        repeat (3) @(negedge clk);

`ifdef ALU_ARB_STATS_EN
        // ---- grant counter saturation ----
        s_req = 2'b01;
        repeat (1250) @(negedge clk);
        s_req = 2'b00;
        repeat (6) @(negedge clk);
        chk("st gcnt0 i0", 32'(bus2.gcnt0), 32'hFF);
        chk("st gcnt0 i1", 32'(bus1.gcnt0), 32'hFF);
        chk("st gcnt1 i0", 32'(bus2.gcnt1), 32'h0);
        s_req = 2'b10;
        @(negedge clk);
        s_req = 2'b00;
        repeat (5) @(negedge clk);
        chk("st gcnt1 one", 32'(bus1.gcnt1), 32'h1);
        chk("st gcnt0 held", 32'(bus2.gcnt0), 32'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
